// File: rtl/conv_line_feeder_pkg.sv
// Shared constants and types for the convolution line feeder and its core.
// Kernel geometry, FSM encoding and ring-index arithmetic live here.
package conv_line_feeder_pkg;

    localparam int NB_PIXEL_DEFAULT = 8;
    localparam int KNL_SIZE         = 3;
    localparam int KNL_LOAD_CYCLES  = 4;
    localparam int RING_SIZE        = KNL_SIZE;
    localparam int NB_RING          = 2;

    typedef logic [NB_RING-1:0] ring_idx_t;

    typedef enum logic [1:0] {
        KNL_CAPTURE = 2'd0,
        KNL_EMIT    = 2'd1,
        FILL        = 2'd2,
        BURST       = 2'd3
    } state_t;

    // (base + step) mod RING_SIZE, for base/step already inside the ring
    function automatic ring_idx_t ring_add(input ring_idx_t base, input ring_idx_t step);
        logic [NB_RING:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        if (sum >= 3'(RING_SIZE)) begin
            sum = sum - 3'(RING_SIZE);
        end
        return sum[NB_RING-1:0];
    endfunction

endpackage

// File: rtl/conv_line_feeder_if.sv
// Stream-side and core-side signals of the line feeder, bundled as one bus.
// master drives the pixel/kernel streams; slave is the feeder itself.
interface conv_line_feeder_if
    import conv_line_feeder_pkg::*;
#(
    parameter int NB_PIXEL = NB_PIXEL_DEFAULT
);
    logic [3*NB_PIXEL-1:0] i_knl_col;
    logic                  i_knl_valid;
    logic                  o_knl_ready;
    logic [NB_PIXEL-1:0]   i_pixel;
    logic                  i_pixel_valid;
    logic                  o_pixel_ready;
    logic [NB_PIXEL-1:0]   o_data1;
    logic [NB_PIXEL-1:0]   o_data2;
    logic [NB_PIXEL-1:0]   o_data3;
    logic                  o_load_knl;
    logic                  o_data_valid;
    logic                  o_frame_done;

    modport master (
        output i_knl_col, i_knl_valid, i_pixel, i_pixel_valid,
        input  o_knl_ready, o_pixel_ready, o_data1, o_data2, o_data3,
               o_load_knl, o_data_valid, o_frame_done
    );

    modport slave (
        input  i_knl_col, i_knl_valid, i_pixel, i_pixel_valid,
        output o_knl_ready, o_pixel_ready, o_data1, o_data2, o_data3,
               o_load_knl, o_data_valid, o_frame_done
    );

endinterface

// File: rtl/conv_line_ram.sv
// One image line: single write port, single read port, registered read.
// The read register only updates when re is high, so it holds between bursts.
module conv_line_ram #(
    parameter int DEPTH   = 64,
    parameter int WIDTH   = 8,
    parameter int NB_ADDR = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [NB_ADDR-1:0] waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               re,
    input  logic [NB_ADDR-1:0] raddr,
    output logic [WIDTH-1:0]   rdata
);

    // NOTE: the storage array has no reset; every location is rewritten before it is read.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/conv_line_feeder.sv
// Front end of the 3x3 convolution core: replays the kernel as a load burst,
// then streams each completed image row as gap-free vertical pixel triplets.
module conv_line_feeder
    import conv_line_feeder_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int NB_PIXEL   = NB_PIXEL_DEFAULT,
    parameter int NB_ADDR    = $clog2(IMG_WIDTH)
) (
    input  logic              clk,
    input  logic              i_rst,
    conv_line_feeder_if.slave bus
);

    localparam int NB_CNT = $clog2(IMG_WIDTH + 2);
    localparam int NB_ROW = $clog2(IMG_HEIGHT + 1);
    localparam int NB_KNL = KNL_SIZE * NB_PIXEL;

    typedef logic [NB_PIXEL-1:0] pixel_t;

    state_t             state;
    logic [1:0]         knl_cnt;
    logic [1:0]         emit_cnt;
    logic [NB_KNL-1:0]  knl_reg [KNL_SIZE];
    pixel_t             knl_out [KNL_SIZE];
    logic               out_from_ram;
    ring_idx_t          out_base;
    logic [NB_ADDR-1:0] col;
    logic [NB_ROW-1:0]  row;
    ring_idx_t          wr_buf;
    logic [NB_CNT-1:0]  rd_cnt;
    logic               last_burst;
    logic               load_knl;
    logic               data_valid;
    logic               frame_done;

    logic               knl_fire;
    logic               pix_fire;
    logic               ram_re;
    pixel_t             ram_q    [RING_SIZE];
    pixel_t             data_out [KNL_SIZE];

    // Tap 0 is the top coefficient, held in the most significant byte.
    function automatic pixel_t knl_tap(input logic [NB_KNL-1:0] column, input int tap);
        return column[NB_KNL-1-tap*NB_PIXEL -: NB_PIXEL];
    endfunction

    assign knl_fire = bus.i_knl_valid && (state == KNL_CAPTURE);
    assign pix_fire = bus.i_pixel_valid && (state == FILL);
    assign ram_re   = (state == BURST) && (rd_cnt < NB_CNT'(IMG_WIDTH));

    for (genvar b = 0; b < RING_SIZE; b++) begin : g_line
        conv_line_ram #(
            .DEPTH   (IMG_WIDTH),
            .WIDTH   (NB_PIXEL),
            .NB_ADDR (NB_ADDR)
        ) u_ram (
            .clk   (clk),
            .we    (pix_fire && (wr_buf == ring_idx_t'(b))),
            .waddr (col),
            .wdata (bus.i_pixel),
            .re    (ram_re),
            .raddr (rd_cnt[NB_ADDR-1:0]),
            .rdata (ram_q[b])
        );
    end

    // NOTE: sequential state uses <= only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state        <= KNL_CAPTURE;
            knl_cnt      <= '0;
            emit_cnt     <= '0;
            out_from_ram <= 1'b0;
            out_base     <= '0;
            col          <= '0;
            row          <= '0;
            wr_buf       <= '0;
            rd_cnt       <= '0;
            last_burst   <= 1'b0;
            load_knl     <= 1'b0;
            data_valid   <= 1'b0;
            frame_done   <= 1'b0;
            for (int t = 0; t < KNL_SIZE; t++) begin
                knl_reg[t] <= '0;
                knl_out[t] <= '0;
            end
        end else begin
            load_knl   <= 1'b0;
            frame_done <= 1'b0;
            // Strobe lands one cycle after the core has shifted in column rd_cnt-1 (>= 2).
            data_valid <= (state == BURST) && (rd_cnt >= NB_CNT'(KNL_SIZE))
                          && (rd_cnt <= NB_CNT'(IMG_WIDTH));

            case (state)
                KNL_CAPTURE: begin
                    if (knl_fire) begin
                        knl_reg[knl_cnt] <= bus.i_knl_col;
                        if (knl_cnt == 2'(KNL_SIZE - 1)) begin
                            knl_cnt      <= '0;
                            emit_cnt     <= '0;
                            state        <= KNL_EMIT;
                            load_knl     <= 1'b1;
                            out_from_ram <= 1'b0;
                            for (int t = 0; t < KNL_SIZE; t++) begin
                                knl_out[t] <= knl_tap(knl_reg[0], t);
                            end
                        end else begin
                            knl_cnt <= knl_cnt + 2'd1;
                        end
                    end
                end

                KNL_EMIT: begin
                    // emit_cnt is the load cycle currently on the outputs.
                    if (emit_cnt == 2'(KNL_LOAD_CYCLES - 1)) begin
                        state  <= FILL;
                        col    <= '0;
                        row    <= '0;
                        wr_buf <= '0;
                    end else begin
                        load_knl <= 1'b1;
                        emit_cnt <= emit_cnt + 2'd1;
                        for (int t = 0; t < KNL_SIZE; t++) begin
                            if (emit_cnt < 2'(KNL_SIZE - 1)) begin
                                knl_out[t] <= knl_tap(knl_reg[emit_cnt + 2'd1], t);
                            end else begin
                                knl_out[t] <= '0;
                            end
                        end
                    end
                end

                FILL: begin
                    if (pix_fire) begin
                        if (col == NB_ADDR'(IMG_WIDTH - 1)) begin
                            col    <= '0;
                            row    <= row + 1'b1;
                            wr_buf <= ring_add(wr_buf, ring_idx_t'(1));
                            if (row >= NB_ROW'(KNL_SIZE - 1)) begin
                                state      <= BURST;
                                rd_cnt     <= '0;
                                last_burst <= (row == NB_ROW'(IMG_HEIGHT - 1));
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end

                BURST: begin
                    // After a wrap, wr_buf points at the oldest of the three rows.
                    if (rd_cnt == '0) begin
                        out_from_ram <= 1'b1;
                        out_base     <= wr_buf;
                    end
                    if (rd_cnt == NB_CNT'(IMG_WIDTH + 1)) begin
                        rd_cnt <= '0;
                        if (last_burst) begin
                            frame_done <= 1'b1;
                            state      <= KNL_CAPTURE;
                            row        <= '0;
                            wr_buf     <= '0;
                        end else begin
                            state <= FILL;
                        end
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end

                default: state <= KNL_CAPTURE;
            endcase
        end
    end

    // NOTE: each output gets its default before the override, so no latch is inferred.
    always_comb begin
        for (int t = 0; t < KNL_SIZE; t++) begin
            data_out[t] = knl_out[t];
            if (out_from_ram) begin
                data_out[t] = ram_q[ring_add(out_base, ring_idx_t'(t))];
            end
        end
    end

    assign bus.o_knl_ready   = (state == KNL_CAPTURE);
    assign bus.o_pixel_ready = (state == FILL);
    assign bus.o_data1       = data_out[0];
    assign bus.o_data2       = data_out[1];
    assign bus.o_data3       = data_out[2];
    assign bus.o_load_knl    = load_knl;
    assign bus.o_data_valid  = data_valid;
    assign bus.o_frame_done  = frame_done;

endmodule

// File: tb/tb_conv_line_feeder.sv
// Directed bench for conv_line_feeder: a 4x4 instance for kernel load, bursts,
// stalls and mid-burst reset, plus a 5x3 instance for the odd-width frame.
module tb_conv_line_feeder;
    import conv_line_feeder_pkg::*;

    localparam int W_A = 4;
    localparam int H_A = 4;
    localparam int W_B = 5;
    localparam int H_B = 3;
    localparam int NP  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    always #5 clk = ~clk;

    conv_line_feeder_if #(.NB_PIXEL(NP)) bus_a ();
    conv_line_feeder_if #(.NB_PIXEL(NP)) bus_b ();

    conv_line_feeder #(.IMG_WIDTH(W_A), .IMG_HEIGHT(H_A), .NB_PIXEL(NP)) dut_a (
        .clk   (clk),
        .i_rst (rst),
        .bus   (bus_a)
    );

    conv_line_feeder #(.IMG_WIDTH(W_B), .IMG_HEIGHT(H_B), .NB_PIXEL(NP)) dut_b (
        .clk   (clk),
        .i_rst (rst),
        .bus   (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] triplet_a();
        return {bus_a.o_data1, bus_a.o_data2, bus_a.o_data3};
    endfunction

    function automatic logic [23:0] triplet_b();
        return {bus_b.o_data1, bus_b.o_data2, bus_b.o_data3};
    endfunction

    function automatic bit ready(input bit sel, input bit pix);
        if (sel) return pix ? bus_b.o_pixel_ready : bus_b.o_knl_ready;
        return pix ? bus_a.o_pixel_ready : bus_a.o_knl_ready;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat, hold it until accepted (bounded), then drop valid.
    task automatic send_beat(input bit sel, input bit pix, input logic [23:0] val, input int gap);
        int t;
        repeat (gap) tick();
        if (sel) begin
            if (pix) begin bus_b.i_pixel = val[7:0]; bus_b.i_pixel_valid = 1'b1; end
            else     begin bus_b.i_knl_col = val;    bus_b.i_knl_valid   = 1'b1; end
        end else begin
            if (pix) begin bus_a.i_pixel = val[7:0]; bus_a.i_pixel_valid = 1'b1; end
            else     begin bus_a.i_knl_col = val;    bus_a.i_knl_valid   = 1'b1; end
        end
        t = 0;
        @(negedge clk);
        while (!ready(sel, pix) && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (!ready(sel, pix)) check(pix ? "pixel_ready_timeout" : "knl_ready_timeout", 0, 1);
        tick();
        bus_a.i_pixel_valid = 1'b0;
        bus_a.i_knl_valid   = 1'b0;
        bus_b.i_pixel_valid = 1'b0;
        bus_b.i_knl_valid   = 1'b0;
    endtask

    task automatic load_kernel_a(input logic [23:0] k0, input logic [23:0] k1,
                                 input logic [23:0] k2, input int gap);
        logic [23:0] exp;
        send_beat(1'b0, 1'b0, k0, gap);
        send_beat(1'b0, 1'b0, k1, gap + 1);
        send_beat(1'b0, 1'b0, k2, 0);
        for (int c = 0; c < KNL_LOAD_CYCLES; c++) begin
            exp = (c == 0) ? k0 : (c == 1) ? k1 : (c == 2) ? k2 : 24'h0;
            @(negedge clk);
            check("load_strobe", bus_a.o_load_knl, 1);
            check("load_column", triplet_a(), exp);
            check("load_pixel_ready", bus_a.o_pixel_ready, 0);
            check("load_no_valid", bus_a.o_data_valid, 0);
            tick();
        end
        @(negedge clk);
        check("load_end", bus_a.o_load_knl, 0);
        check("fill_pixel_ready", bus_a.o_pixel_ready, 1);
        tick();
    endtask

    task automatic feed_row_a(input int r, input int base, input bit stall);
        for (int k = 0; k < W_A; k++) begin
            send_beat(1'b0, 1'b1, 24'(base + r * W_A + k), stall ? (k * 7 + r) % 3 : 0);
        end
    endtask

    // Entered in burst cycle 0, right after the edge that took the row's last pixel.
    task automatic check_burst_a(input int r, input int base, input bit last);
        logic [23:0] exp;
        for (int c = 0; c <= W_A + 1; c++) begin
            @(negedge clk);
            check("burst_pixel_ready", bus_a.o_pixel_ready, 0);
            if (c >= 1 && c <= W_A) begin
                exp = {8'(base + (r - 2) * W_A + c - 1), 8'(base + (r - 1) * W_A + c - 1),
                       8'(base + r * W_A + c - 1)};
                check("burst_column", triplet_a(), exp);
            end
            check("burst_valid", bus_a.o_data_valid, (c >= 4 && c <= W_A + 1) ? 1 : 0);
            check("burst_no_load", bus_a.o_load_knl, 0);
            tick();
        end
        @(negedge clk);
        check("post_burst_valid", bus_a.o_data_valid, 0);
        check("frame_done_pulse", bus_a.o_frame_done, last ? 1 : 0);
        if (last) check("frame_end_knl_ready", bus_a.o_knl_ready, 1);
        else      check("refill_pixel_ready", bus_a.o_pixel_ready, 1);
        tick();
        if (last) begin
            @(negedge clk);
            check("frame_done_single", bus_a.o_frame_done, 0);
            tick();
        end
    endtask

    task automatic run_frame_a(input int base, input bit stall);
        for (int r = 0; r < H_A; r++) begin
            feed_row_a(r, base, stall);
            if (r >= 2) check_burst_a(r, base, r == H_A - 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nv;
        int nd;
        int first_v;
        int last_v;
        int done_c;

        bus_a.i_knl_col = '0; bus_a.i_knl_valid = 1'b0;
        bus_a.i_pixel   = '0; bus_a.i_pixel_valid = 1'b0;
        bus_b.i_knl_col = '0; bus_b.i_knl_valid = 1'b0;
        bus_b.i_pixel   = '0; bus_b.i_pixel_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_data", triplet_a(), 24'h0);
        check("reset_load", bus_a.o_load_knl, 0);
        check("reset_valid", bus_a.o_data_valid, 0);
        check("reset_done", bus_a.o_frame_done, 0);
        check("reset_knl_ready", bus_a.o_knl_ready, 1);
        check("reset_pixel_ready", bus_a.o_pixel_ready, 0);
        tick();

        // Kernel with valid gaps, then a clean frame (first burst and ring wrap).
        load_kernel_a(24'h010203, 24'h040506, 24'h070809, 1);
        run_frame_a(0, 1'b0);

        // Second frame with pixel stalls; content and timing must be unchanged.
        load_kernel_a(24'h0a0b0c, 24'h0d0e0f, 24'h101112, 0);
        run_frame_a(8'h20, 1'b1);

        // Reset during burst cycle 2 of a frame, then a fresh frame.
        load_kernel_a(24'h212223, 24'h242526, 24'h272829, 0);
        for (int r = 0; r < 3; r++) feed_row_a(r, 8'h40, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_data", triplet_a(), 24'h0);
        check("abort_load", bus_a.o_load_knl, 0);
        check("abort_valid", bus_a.o_data_valid, 0);
        check("abort_done", bus_a.o_frame_done, 0);
        check("abort_knl_ready", bus_a.o_knl_ready, 1);
        check("abort_pixel_ready", bus_a.o_pixel_ready, 0);
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("abort_no_trailing_valid", bus_a.o_data_valid, 0);
            tick();
        end
        load_kernel_a(24'h313233, 24'h343536, 24'h373839, 0);
        run_frame_a(8'h80, 1'b0);

        // Odd width instance: 5 pixels per row, 3 rows -> one burst.
        send_beat(1'b1, 1'b0, 24'h010101, 0);
        send_beat(1'b1, 1'b0, 24'h020202, 0);
        send_beat(1'b1, 1'b0, 24'h030303, 0);
        for (int r = 0; r < H_B; r++) begin
            for (int k = 0; k < W_B; k++) send_beat(1'b1, 1'b1, 24'(r * W_B + k), 0);
        end
        nv = 0; nd = 0; first_v = -1; last_v = -1; done_c = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 1)   check("odd_first_column", triplet_b(), {8'd0, 8'd5, 8'd10});
            if (c == W_B) check("odd_last_column", triplet_b(), {8'd4, 8'd9, 8'd14});
            if (bus_b.o_data_valid) begin
                nv++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
            if (bus_b.o_frame_done) begin
                nd++;
                done_c = c;
            end
            tick();
        end
        check("odd_valid_count", nv, 3);
        check("odd_first_valid_cycle", first_v, 4);
        check("odd_last_valid_cycle", last_v, W_B + 1);
        check("odd_done_count", nd, 1);
        check("odd_done_cycle", done_c, W_B + 2);
        check("odd_knl_ready", bus_b.o_knl_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
